mem_stage_ctrl: RTL

Memory-stage controller of the LC-3b pipeline, directly downstream of the execute stage. It takes the effective address and store data that execute latches into the EX/MEM register, runs the data-memory handshake for LDR/STR/LDB/STB/LDI/STI, and stalls the pipeline until the access completes. It returns the load result, sign-extended for byte loads, to the MEM/WB register.

---
 rtl/mem_stage_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_ctrl.sv
// LC-3b memory-stage controller: drives the data-memory handshake for loads/stores incl. indirect.
// Latency: 2 cycles accept->done for single accesses, 3 for indirect, plus memory wait cycles.
// Backpressure: mem_stall holds upstream stages while an access is in flight; waits on dmem_resp.
module mem_stage_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [2:0]  mem_op,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [1:0]  dmem_wmask,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        mem_stall,
    output logic        mem_done,
    output logic [15:0] load_data
);

    localparam logic [2:0] OP_LDW = 3'd1;
    localparam logic [2:0] OP_STW = 3'd2;
    localparam logic [2:0] OP_LDB = 3'd3;
    localparam logic [2:0] OP_STB = 3'd4;
    localparam logic [2:0] OP_LDI = 3'd5;
    localparam logic [2:0] OP_STI = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [2:0]  op_q, op_n;
    logic        addr_lsb_q, addr_lsb_n;   // byte lane select for LDB
    logic [15:0] wdata_q, wdata_n;         // store data kept for the STI second access

    logic [15:0] address_n;
    logic        read_n;
    logic        write_n;
    logic [1:0]  wmask_n;
    logic [15:0] dwdata_n;
    logic [15:0] load_n;
    logic        done_n;

    logic        accept;
    logic        is_indirect;
    logic [7:0]  byte_sel;

    assign accept      = ex_valid && (mem_op != 3'd0) && (mem_op != 3'd7);
    assign is_indirect = (op_q == OP_LDI) || (op_q == OP_STI);
    assign byte_sel    = addr_lsb_q ? dmem_rdata[15:8] : dmem_rdata[7:0];

    // Next-state logic plus next values of every registered output.
    always_comb begin
        state_n    = state;
        op_n       = op_q;
        addr_lsb_n = addr_lsb_q;
        wdata_n    = wdata_q;
        address_n  = dmem_address;
        read_n     = dmem_read;
        write_n    = dmem_write;
        wmask_n    = dmem_wmask;
        dwdata_n   = dmem_wdata;
        load_n     = load_data;
        done_n     = 1'b0;
        mem_stall  = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    mem_stall  = 1'b1;
                    state_n    = ACC1;
                    op_n       = mem_op;
                    addr_lsb_n = mem_addr[0];
                    wdata_n    = mem_wdata;
                    // Word accesses force address bit 0 low; only byte ops use the full address.
                    address_n  = {mem_addr[15:1], 1'b0};
                    read_n     = 1'b0;
                    write_n    = 1'b0;
                    wmask_n    = 2'b00;
                    case (mem_op)
                        OP_STW: begin
                            write_n  = 1'b1;
                            wmask_n  = 2'b11;
                            dwdata_n = mem_wdata;
                        end
                        OP_LDB: begin
                            read_n    = 1'b1;
                            address_n = mem_addr;
                        end
                        OP_STB: begin
                            write_n   = 1'b1;
                            address_n = mem_addr;
                            wmask_n   = mem_addr[0] ? 2'b10 : 2'b01;
                            dwdata_n  = {mem_wdata[7:0], mem_wdata[7:0]};
                        end
                        default: begin
                            // LDW, and the pointer read of LDI/STI
                            read_n = 1'b1;
                        end
                    endcase
                end
            end

            ACC1: begin
                mem_stall = 1'b1;
                if (dmem_resp) begin
                    if (is_indirect) begin
                        // Pointer returned: the register now holds it as the next address.
                        state_n   = ACC2;
                        address_n = {dmem_rdata[15:1], 1'b0};
                        if (op_q == OP_STI) begin
                            read_n   = 1'b0;
                            write_n  = 1'b1;
                            wmask_n  = 2'b11;
                            dwdata_n = wdata_q;
                        end else begin
                            read_n  = 1'b1;
                            write_n = 1'b0;
                            wmask_n = 2'b00;
                        end
                    end else begin
                        state_n = DONE;
                        read_n  = 1'b0;
                        write_n = 1'b0;
                        wmask_n = 2'b00;
                        done_n  = 1'b1;
                        if (op_q == OP_LDW)
                            load_n = dmem_rdata;
                        else if (op_q == OP_LDB)
                            load_n = {{8{byte_sel[7]}}, byte_sel};
                    end
                end
            end

            ACC2: begin
                mem_stall = 1'b1;
                if (dmem_resp) begin
                    state_n = DONE;
                    read_n  = 1'b0;
                    write_n = 1'b0;
                    wmask_n = 2'b00;
                    done_n  = 1'b1;
                    if (op_q == OP_LDI)
                        load_n = dmem_rdata;
                end
            end

            default: begin
                // DONE: EX/MEM still holds the finished instruction, so inputs are ignored.
                state_n = IDLE;
            end
        endcase
    end

    // State and registered outputs, synchronous reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            op_q         <= 3'd0;
            addr_lsb_q   <= 1'b0;
            wdata_q      <= 16'h0000;
            dmem_address <= 16'h0000;
            dmem_read    <= 1'b0;
            dmem_write   <= 1'b0;
            dmem_wmask   <= 2'b00;
            dmem_wdata   <= 16'h0000;
            load_data    <= 16'h0000;
            mem_done     <= 1'b0;
        end else begin
            state        <= state_n;
            op_q         <= op_n;
            addr_lsb_q   <= addr_lsb_n;
            wdata_q      <= wdata_n;
            dmem_address <= address_n;
            dmem_read    <= read_n;
            dmem_write   <= write_n;
            dmem_wmask   <= wmask_n;
            dmem_wdata   <= dwdata_n;
            load_data    <= load_n;
            mem_done     <= done_n;
        end
    end

endmodule
